// File: rtl/dcache_flush_seq_if.sv
// rtl/dcache_flush_seq_if.sv - flush request, write-buffer and tag-array handshake bundle for the dcache flush sequencer
interface dcache_flush_seq_if #(
    parameter int NumSets = 256,
    parameter int NumWays = 8
);
    localparam int IdxW = $clog2(NumSets);

    logic              flush_req_i;
    logic              flush_ack_o;
    logic              busy_o;
    logic              stall_o;
    logic              wbuf_empty_i;
    logic              tag_req_o;
    logic              tag_gnt_i;
    logic [IdxW-1:0]   tag_idx_o;
    logic [NumWays-1:0] tag_way_o;

    modport master (
        input  flush_req_i,
        input  wbuf_empty_i,
        input  tag_gnt_i,
        output flush_ack_o,
        output busy_o,
        output stall_o,
        output tag_req_o,
        output tag_idx_o,
        output tag_way_o
    );

    modport slave (
        output flush_req_i,
        output wbuf_empty_i,
        output tag_gnt_i,
        input  flush_ack_o,
        input  busy_o,
        input  stall_o,
        input  tag_req_o,
        input  tag_idx_o,
        input  tag_way_o
    );
endinterface

// File: rtl/dcache_flush_seq.sv
// rtl/dcache_flush_seq.sv - drains the write buffer then invalidates every set of the write-through dcache
module dcache_flush_seq #(
    parameter int NumSets = 256,
    parameter int NumWays = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    dcache_flush_seq_if.master  bus
);
    localparam int IdxW = $clog2(NumSets);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        INV   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.flush_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.wbuf_empty_i) begin
                    cnt_d   = '0;
                    state_d = INV;
                end
            end
            INV: begin
                // Last set goes straight to DONE so the counter never wraps.
                if (bus.tag_gnt_i) begin
                    if (cnt_q == LastIdx) state_d = DONE;
                    else                  cnt_d   = cnt_q + IdxW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the registered state and counter.
    assign bus.tag_req_o   = (state_q == INV);
    assign bus.tag_idx_o   = (state_q == INV) ? cnt_q : '0;
    assign bus.tag_way_o   = (state_q == INV) ? '1 : '0;
    assign bus.flush_ack_o = (state_q == DONE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.stall_o     = (state_q != IDLE);
endmodule

// File: tb/tb_dcache_flush_seq.sv
// tb/tb_dcache_flush_seq.sv - scenario and randomized checks of dcache_flush_seq against a flush-progress model
module tb_dcache_flush_seq;
    localparam int NS = 4;
    localparam int NW = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    // Model: a flush is either draining, has m_left sets still to invalidate, or is acknowledging.
    bit   m_drain;
    int   m_left;
    bit   m_ack;

    dcache_flush_seq_if #(.NumSets(NS), .NumWays(NW)) bus ();

    dcache_flush_seq #(.NumSets(NS), .NumWays(NW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {bus.flush_ack_o, bus.busy_o, bus.stall_o, bus.tag_req_o, bus.tag_idx_o, bus.tag_way_o};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic       inv;
        logic       busy;
        logic [1:0] idx;
        inv  = (m_left > 0);
        busy = m_drain || inv || m_ack;
        idx  = inv ? 2'(NS - m_left) : 2'd0;
        return {m_ack, busy, busy, inv, idx, inv ? 8'hFF : 8'h00};
    endfunction

    task automatic model_clear();
        m_drain = 1'b0;
        m_left  = 0;
        m_ack   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n)            model_clear();
        else if (m_ack)        m_ack = 1'b0;
        else if (m_left > 0) begin
            if (bus.tag_gnt_i) begin
                m_left--;
                if (m_left == 0) m_ack = 1'b1;
            end
        end else if (m_drain) begin
            if (bus.wbuf_empty_i) begin
                m_drain = 1'b0;
                m_left  = NS;
            end
        end else if (bus.flush_req_i) m_drain = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush_req_i = 1'b1;
        bus.wbuf_empty_i = 1'b1;
        bus.tag_gnt_i = 1'b1;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", obs());
        end
        tick();
        tick();
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_holds_with_req got=%h exp=0", obs());
        end
        bus.flush_req_i = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL idle_after_release got=%h exp=0", obs());
        end
    endtask

    task automatic test_basic();
        int idx_q[$];
        int first_k;
        int ack_k;
        first_k = -1;
        ack_k   = -1;
        bus.wbuf_empty_i = 1'b1;
        bus.tag_gnt_i = 1'b1;
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_cycle k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
            if (bus.tag_req_o) begin
                if (first_k < 0) first_k = k;
                idx_q.push_back(int'(bus.tag_idx_o));
            end
            if (bus.flush_ack_o && ack_k < 0) ack_k = k;
            tick();
        end
        n_cmp++;
        if (ack_k !== 6) begin
            n_fail++;
            $display("FAIL basic_ack_latency got=%0d exp=6", ack_k);
        end
        n_cmp++;
        if (first_k !== 2 || idx_q.size() !== 4) begin
            n_fail++;
            $display("FAIL basic_inv_window got first=%0d count=%0d exp first=2 count=4", first_k, idx_q.size());
        end
        for (int i = 0; i < idx_q.size(); i++) begin
            n_cmp++;
            if (idx_q[i] !== i) begin
                n_fail++;
                $display("FAIL basic_idx_seq pos=%0d got=%0d exp=%0d", i, idx_q[i], i);
            end
        end
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_after got=%b exp=0", bus.busy_o);
        end
    endtask

    task automatic test_drain();
        bus.tag_gnt_i = 1'b1;
        bus.wbuf_empty_i = 1'b0;
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (bus.tag_req_o !== 1'b0 || bus.stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_hold k=%0d got req=%b stall=%b exp req=0 stall=1", k, bus.tag_req_o, bus.stall_o);
            end
            tick();
        end
        bus.wbuf_empty_i = 1'b1;
        tick();
        n_cmp++;
        if (bus.tag_req_o !== 1'b1 || bus.tag_idx_o !== 2'd0) begin
            n_fail++;
            $display("FAIL drain_inv_start got req=%b idx=%0d exp req=1 idx=0", bus.tag_req_o, bus.tag_idx_o);
        end
        bus.wbuf_empty_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_rest k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
            tick();
        end
        bus.wbuf_empty_i = 1'b1;
    endtask

    task automatic test_backpressure();
        int gnt_q[$];
        int held;
        int on2;
        held = 0;
        on2  = 0;
        bus.wbuf_empty_i = 1'b1;
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (bus.tag_req_o && bus.tag_idx_o == 2'd2 && held < 3) begin
                bus.tag_gnt_i = 1'b0;
                held++;
            end else begin
                bus.tag_gnt_i = 1'b1;
            end
            if (bus.tag_req_o && bus.tag_idx_o == 2'd2) on2++;
            if (bus.tag_req_o && bus.tag_gnt_i) gnt_q.push_back(int'(bus.tag_idx_o));
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bp_cycle k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
            tick();
        end
        bus.tag_gnt_i = 1'b1;
        n_cmp++;
        if (on2 !== 4) begin
            n_fail++;
            $display("FAIL bp_hold_set2 got=%0d exp=4", on2);
        end
        n_cmp++;
        if (gnt_q.size() !== NS) begin
            n_fail++;
            $display("FAIL bp_grant_count got=%0d exp=%0d", gnt_q.size(), NS);
        end
        for (int i = 0; i < gnt_q.size(); i++) begin
            n_cmp++;
            if (gnt_q[i] !== i) begin
                n_fail++;
                $display("FAIL bp_grant_order pos=%0d got=%0d exp=%0d", i, gnt_q[i], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        int first_idx;
        acks = 0;
        first_idx = -1;
        bus.wbuf_empty_i = 1'b1;
        bus.tag_gnt_i = 1'b1;
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        for (int i = 0; i < 20 && !(bus.tag_req_o && bus.tag_idx_o == 2'd1); i++) tick();
        n_cmp++;
        if (bus.tag_req_o !== 1'b1 || bus.tag_idx_o !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_reach_set1 got req=%b idx=%0d exp req=1 idx=1", bus.tag_req_o, bus.tag_idx_o);
        end
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL rstmid_async_clear got=%h exp=0", obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.flush_ack_o) acks++;
            tick();
        end
        n_cmp++;
        if (acks !== 0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_ack got acks=%0d busy=%b exp acks=0 busy=0", acks, bus.busy_o);
        end
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.tag_req_o && first_idx < 0) first_idx = int'(bus.tag_idx_o);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_restart k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
            tick();
        end
        n_cmp++;
        if (first_idx !== 0) begin
            n_fail++;
            $display("FAIL rstmid_restart_set got=%0d exp=0", first_idx);
        end
    endtask

    task automatic test_back_to_back();
        int ack_t[$];
        int acks;
        int saw_inv;
        bus.wbuf_empty_i = 1'b1;
        bus.tag_gnt_i = 1'b1;
        bus.flush_req_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (bus.flush_ack_o) ack_t.push_back(k);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_cycle k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
            tick();
        end
        n_cmp++;
        if (ack_t.size() < 3) begin
            n_fail++;
            $display("FAIL b2b_ack_count got=%0d exp>=3", ack_t.size());
        end
        for (int i = 1; i < ack_t.size(); i++) begin
            n_cmp++;
            if (ack_t[i] - ack_t[i-1] !== NS + 3) begin
                n_fail++;
                $display("FAIL b2b_ack_spacing i=%0d got=%0d exp=%0d", i, ack_t[i] - ack_t[i-1], NS + 3);
            end
        end
        bus.flush_req_i = 1'b0;
        for (int i = 0; i < 30 && bus.busy_o; i++) tick();
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain_timeout got busy=%b exp=0", bus.busy_o);
        end
        model_clear();
        // Single flush with a stray request pulse while invalidating.
        acks = 0;
        saw_inv = 0;
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.tag_req_o && bus.tag_idx_o == 2'd1 && saw_inv == 0) begin
                bus.flush_req_i = 1'b1;
                saw_inv = 1;
            end else begin
                bus.flush_req_i = 1'b0;
            end
            if (bus.flush_ack_o) acks++;
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL inv_pulse_cycle k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
            tick();
        end
        bus.flush_req_i = 1'b0;
        n_cmp++;
        if (acks !== 1 || saw_inv !== 1 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_pulse_ignored got acks=%0d pulsed=%0d busy=%b exp acks=1 pulsed=1 busy=0", acks, saw_inv, bus.busy_o);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            bus.flush_req_i  = ($urandom_range(0, 3) == 0);
            bus.wbuf_empty_i = ($urandom_range(0, 3) != 0);
            bus.tag_gnt_i    = ($urandom_range(0, 2) != 0);
            tick();
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.flush_req_i  = 1'b0;
        bus.wbuf_empty_i = 1'b0;
        bus.tag_gnt_i    = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_drain();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
